// File: rtl/mem_io_pkg.sv
// Purpose: shared types and constants for the mem_io_ctrl bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_io_pkg;

  // Transaction engine states.
  typedef enum logic [2:0] {
    IDLE,
    IO,
    SETUP,
    WAIT,
    DONE
  } state_t;

  // Register offsets below IO_ADDR.
  localparam int IO_SW_HEX_OFS = 0;
  localparam int IO_LED_OFS    = 1;

endpackage

// File: rtl/mem_io_regs.sv
// Purpose: memory-mapped IO register file (hex digits, optional LED), decode and read mux.
// Latency: reads are combinational on rd_addr_i; writes land on the clock edge where wr_en_i is high.
// Backpressure: none; every write is accepted.
//
// Ports: clk/rst; rd_addr_i -> io_hit_o, rd_data_o (decode + read mux);
//        wr_en_i/wr_addr_i/wr_data_i (register write); sw_i (switches);
//        hex_o (digit 0 in [3:0]); led_o only when MMIO_LED_EN is defined.
module mem_io_regs
  import mem_io_pkg::*;
#(
  parameter int              DATA_W     = 16,
  parameter int              ADDR_W     = 16,
  parameter int              SW_W       = 10,
  parameter int              HEX_DIGITS = 4,
  parameter logic [ADDR_W-1:0] IO_ADDR  = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  output logic                    io_hit_o,
  output logic [DATA_W-1:0]       rd_data_o,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic [SW_W-1:0]         sw_i,
  output logic [4*HEX_DIGITS-1:0] hex_o
`ifdef MMIO_LED_EN
  ,
  output logic [SW_W-1:0]         led_o
`endif
);

  localparam logic [ADDR_W-1:0] SW_HEX_ADDR = IO_ADDR - ADDR_W'(IO_SW_HEX_OFS);

  logic [4*HEX_DIGITS-1:0] hex_q, hex_d;

  always_comb begin
    hex_d = hex_q;
    if (wr_en_i && (wr_addr_i == SW_HEX_ADDR)) hex_d = wr_data_i[4*HEX_DIGITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hex_q <= '0;
    else     hex_q <= hex_d;
  end

  assign hex_o = hex_q;

`ifdef MMIO_LED_EN
  localparam logic [ADDR_W-1:0] LED_ADDR = IO_ADDR - ADDR_W'(IO_LED_OFS);

  logic [SW_W-1:0] led_q, led_d;

  always_comb begin
    led_d = led_q;
    if (wr_en_i && (wr_addr_i == LED_ADDR)) led_d = wr_data_i[SW_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_q <= '0;
    else     led_q <= led_d;
  end

  assign led_o = led_q;
`endif

  // Decode and read mux share one chain so the hit flag and data always agree.
  always_comb begin
    io_hit_o  = 1'b0;
    rd_data_o = '0;
    if (rd_addr_i == SW_HEX_ADDR) begin
      io_hit_o  = 1'b1;
      rd_data_o = DATA_W'(sw_i);
    end
`ifdef MMIO_LED_EN
    else if (rd_addr_i == LED_ADDR) begin
      io_hit_o  = 1'b1;
      rd_data_o = DATA_W'(led_q);
    end
`endif
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// Purpose: CPU MAR/MDR to async SRAM bridge with wait states and memory-mapped IO.
// Latency: IO access acks 1 cycle after acceptance, SRAM access acks WAIT_CYCLES+2 cycles after.
// Backpressure: cpu_req is only accepted in IDLE; the CPU holds it until the one-cycle cpu_ack.
//
// Ports: Clk, Reset (async, active high); cpu_req/cpu_we/cpu_addr/cpu_wdata in,
//        cpu_rdata/cpu_ack out; sram_addr/sram_wdata/sram_oe_n/sram_we_n (all from flops),
//        sram_rdata in; Switches in; hex out. Optional macro MMIO_LED_EN adds LED out.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                SW_W        = 10,
  parameter int                HEX_DIGITS  = 4,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR     = 16'hFFFF
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_ack,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [DATA_W-1:0]       sram_wdata,
  input  logic [DATA_W-1:0]       sram_rdata,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  input  logic [SW_W-1:0]         Switches,
  output logic [4*HEX_DIGITS-1:0] hex
`ifdef MMIO_LED_EN
  ,
  output logic [SW_W-1:0]         LED
`endif
);

  // A zero wait-state write would never pulse WE, so refuse to build it.
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_io_ctrl: WAIT_CYCLES must be in 1..15");
  end
  if (SW_W > DATA_W || 4*HEX_DIGITS > DATA_W) begin : g_bad_width
    $error("mem_io_ctrl: SW_W and 4*HEX_DIGITS must not exceed DATA_W");
  end

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;

  logic              io_hit;
  logic [DATA_W-1:0] io_rdata;

  // Decode runs on the live request address so IO read data is ready by the ack cycle;
  // writes use the latched address and land on the edge that ends the IO cycle.
  mem_io_regs #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .SW_W      (SW_W),
    .HEX_DIGITS(HEX_DIGITS),
    .IO_ADDR   (IO_ADDR)
  ) u_regs (
    .clk      (Clk),
    .rst      (Reset),
    .rd_addr_i(cpu_addr),
    .io_hit_o (io_hit),
    .rd_data_o(io_rdata),
    .wr_en_i  ((state_q == IO) && we_q),
    .wr_addr_i(addr_q),
    .wr_data_i(wdata_q),
    .sw_i     (Switches),
    .hex_o    (hex)
`ifdef MMIO_LED_EN
    ,
    .led_o    (LED)
`endif
  );

  // SRAM pins and ack are computed one cycle ahead and registered, so each
  // output reflects the state it is registered into, with no decode glitches.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack_d        = 1'b0;
    rdata_d      = rdata_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          if (io_hit) begin
            state_d = IO;
            ack_d   = 1'b1;
            if (!cpu_we) rdata_d = io_rdata;
          end else begin
            state_d     = SETUP;
            sram_addr_d = cpu_addr;
            if (cpu_we) sram_wdata_d = cpu_wdata;
            else        oe_n_d       = 1'b0;
          end
        end
      end
      IO: state_d = IDLE;
      SETUP: begin
        if (WAIT_CYCLES == 0) begin
          state_d = DONE;
          ack_d   = 1'b1;
          if (!we_q) rdata_d = sram_rdata;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_CYCLES);
          if (we_q) we_n_d = 1'b0;
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          // WE rises entering DONE; address and data stay put for hold time.
          state_d = DONE;
          ack_d   = 1'b1;
          we_n_d  = 1'b1;
          if (!we_q) rdata_d = sram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
    end
  end

  assign cpu_ack    = ack_q;
  assign cpu_rdata  = rdata_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;

endmodule
